// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of the store RAM arbiter.
// Fetch is read-only; data port does loads and stores.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_ack;
  logic [DATA_W-1:0] f_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  modport master (
    output f_req, f_addr,
    output d_req, d_we, d_addr, d_wdata,
    input  f_ack, f_rdata, d_ack, d_rdata
  );

  modport slave (
    input  f_req, f_addr,
    input  d_req, d_we, d_addr, d_wdata,
    output f_ack, f_rdata, d_ack, d_rdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Single-port store RAM controller: init sequencing plus
// round-robin fetch/data arbitration, read latency hidden.
module ram_port_arbiter #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 8,
  parameter int INIT_CYCLES = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  ram_port_arbiter_if.slave bus,
  output logic              ram_WE,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_IN,
  input  logic [DATA_W-1:0] ram_data_Out,
  output logic              ram_Initialize,
  output logic              busy
);

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;
  localparam logic [1:0] S_CAP  = 2'd3;

  localparam int CW =
    (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(INIT_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              init_q, init_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic              fack_q, fack_d;
  logic              dack_q, dack_d;
  logic [DATA_W-1:0] frd_q, frd_d;
  logic [DATA_W-1:0] drd_q, drd_d;
  logic              busy_q, busy_d;
  // last_q/own_q: 1 = data port, 0 = fetch port
  logic              last_q, last_d;
  logic              own_q, own_d;
  logic              wr_q, wr_d;
  logic              f_el, d_el, pick_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_d  = init_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    fack_d  = 1'b0;
    dack_d  = 1'b0;
    frd_d   = frd_q;
    drd_d   = drd_q;
    last_d  = last_q;
    own_d   = own_q;
    wr_d    = wr_q;
    // a requester is still dropping req in its ack cycle
    f_el    = bus.f_req && !fack_q;
    d_el    = bus.d_req && !dack_q;
    pick_d  = d_el && (!f_el || !last_q);
    unique case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          init_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        we_d = 1'b0;
        if (f_el || d_el) begin
          state_d = S_ACC;
          own_d   = pick_d;
          last_d  = pick_d;
          wr_d    = pick_d && bus.d_we;
          we_d    = pick_d && bus.d_we;
          addr_d  = pick_d ? bus.d_addr : bus.f_addr;
          if (pick_d && bus.d_we) wdat_d = bus.d_wdata;
        end
      end
      S_ACC: begin
        we_d    = 1'b0;
        state_d = S_CAP;
      end
      S_CAP: begin
        state_d = S_IDLE;
        if (own_q) begin
          dack_d = 1'b1;
          if (!wr_q) drd_d = ram_data_Out;
        end else begin
          fack_d = 1'b1;
          frd_d  = ram_data_Out;
        end
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      init_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      fack_q  <= 1'b0;
      dack_q  <= 1'b0;
      frd_q   <= '0;
      drd_q   <= '0;
      busy_q  <= 1'b1;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= init_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      fack_q  <= fack_d;
      dack_q  <= dack_d;
      frd_q   <= frd_d;
      drd_q   <= drd_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      own_q   <= own_d;
      wr_q    <= wr_d;
    end
  end

  assign bus.f_ack      = fack_q;
  assign bus.f_rdata    = frd_q;
  assign bus.d_ack      = dack_q;
  assign bus.d_rdata    = drd_q;
  assign ram_WE         = we_q;
  assign ram_addr       = addr_q;
  assign ram_data_IN    = wdat_q;
  assign ram_Initialize = init_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RAM model, directed cases and
// random fetch/data traffic against a memory scoreboard.
module tb_ram_port_arbiter;

  logic       Clock;
  logic       Reset;
  logic       ram_WE;
  logic [4:0] ram_addr;
  logic [7:0] ram_data_IN;
  logic [7:0] ram_data_Out;
  logic       ram_Initialize;
  logic       busy;

  ram_port_arbiter_if #(.ADDR_W(5), .DATA_W(8)) bus();

  ram_port_arbiter #(
    .ADDR_W(5), .DATA_W(8), .INIT_CYCLES(2)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus(bus),
    .ram_WE(ram_WE),
    .ram_addr(ram_addr),
    .ram_data_IN(ram_data_IN),
    .ram_data_Out(ram_data_Out),
    .ram_Initialize(ram_Initialize),
    .busy(busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_run = 0;
  int n_fail = 0;
  logic [7:0] mem [32];
  logic [7:0] ref_mem [32];
  logic [7:0] exp_drd;
  int seq [$];

  function automatic logic [7:0] img(input int a);
    case (a)
      0:       return 8'h80;
      5:       return 8'h7F;
      16:      return 8'h1E;
      default: return 8'(a * 7) ^ 8'h3C;
    endcase
  endfunction

  // RAM: registered read, synchronous write, image load
  always @(posedge Clock) begin
    if (ram_Initialize) begin
      for (int i = 0; i < 32; i++) mem[i] <= img(i);
    end else if (ram_WE) begin
      mem[ram_addr] <= ram_data_IN;
    end
    ram_data_Out <= mem[ram_addr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_ref();
    for (int i = 0; i < 32; i++) ref_mem[i] = img(i);
    exp_drd = 8'h00;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (ram_Initialize && n < 10) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    int n;
    Reset = 1'b1;
    bus.f_req = 1'b0;
    bus.d_req = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    wait_init(n);
    chk("reinit_edges", n, 2);
    load_ref();
  endtask

  // one transaction, scoreboarded against ref_mem
  task automatic xfer(input bit is_d, input bit we,
                      input logic [4:0] a,
                      input logic [7:0] wd,
                      output logic [7:0] rd,
                      output int lat);
    int wes;
    bit got;
    wes = 0;
    lat = 0;
    got = 0;
    rd = 8'h00;
    if (is_d) begin
      bus.d_req = 1'b1;
      bus.d_we = we;
      bus.d_addr = a;
      bus.d_wdata = wd;
    end else begin
      bus.f_req = 1'b1;
      bus.f_addr = a;
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (is_d && ram_WE) begin
        wes++;
        chk("we_addr", ram_addr, a);
        chk("we_data", ram_data_IN, wd);
      end
      if (is_d ? bus.d_ack : bus.f_ack) begin
        got = 1;
        break;
      end
    end
    if (is_d) bus.d_req = 1'b0;
    else bus.f_req = 1'b0;
    if (!got) begin
      chk(is_d ? "d_timeout" : "f_timeout", 0, 1);
    end else if (is_d && we) begin
      chk("we_pulses", wes, 1);
      chk("wr_drd_held", bus.d_rdata, exp_drd);
      ref_mem[a] = wd;
    end else begin
      rd = is_d ? bus.d_rdata : bus.f_rdata;
      chk(is_d ? "d_rdata" : "f_rdata", rd, ref_mem[a]);
      if (is_d) begin
        chk("rd_no_we", wes, 0);
        exp_drd = rd;
      end
    end
  endtask

  task automatic agent(input bit is_d, input int n,
                       input int maxgap);
    logic [7:0] rd;
    int lat;
    bit we;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(maxgap, 0)) tick();
      we = is_d ? 1'($urandom_range(1, 0)) : 1'b0;
      xfer(is_d, we, 5'($urandom_range(31, 0)),
           8'($urandom), rd, lat);
      seq.push_back(int'(is_d));
      chk("lat_bound", (lat >= 3 && lat <= 7), 1);
    end
  endtask

  // cycle-level invariants
  bit fp, dp;
  always @(posedge Clock) begin
    #2;
    if (Reset) begin
      fp = 0;
      dp = 0;
    end else begin
      chk("invariant",
          (bus.f_ack && bus.d_ack) ||
          (ram_WE && (ram_Initialize || !busy)) ||
          (bus.f_ack && fp) || (bus.d_ack && dp), 0);
      fp = bus.f_ack;
      dp = bus.d_ack;
    end
  end

  initial begin
    logic [7:0] r1, r2;
    int l1, l2, n;
    bit act;
    Reset = 1'b1;
    bus.f_req = 1'b0;
    bus.f_addr = '0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    tick();
    chk("rst_init", ram_Initialize, 1);
    chk("rst_busy", busy, 1);
    chk("rst_we", ram_WE, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdat", ram_data_IN, 0);
    chk("rst_acks", {bus.f_ack, bus.d_ack}, 0);
    chk("rst_rdata", {bus.f_rdata, bus.d_rdata}, 0);
    Reset = 1'b0;
    wait_init(n);
    chk("init_edges", n, 2);
    chk("idle_busy", busy, 0);
    load_ref();

    xfer(0, 0, 5'd0, 8'h00, r1, l1);
    chk("f0_data", r1, 8'h80);
    chk("f0_lat", l1, 3);
    xfer(0, 0, 5'd5, 8'h00, r1, l1);
    chk("f5_data", r1, 8'h7F);
    xfer(1, 1, 5'h1E, 8'hA5, r1, l1);
    chk("dw_drd", bus.d_rdata, 8'h00);
    xfer(0, 0, 5'h1E, 8'h00, r1, l1);
    chk("f1e_data", r1, 8'hA5);

    // simultaneous pairs after reset: fetch wins first
    do_reset();
    for (int k = 0; k < 2; k++) begin
      tick();
      fork
        xfer(0, 0, 5'($urandom_range(31, 0)), 8'h0, r1, l1);
        xfer(1, 0, 5'($urandom_range(31, 0)), 8'h0, r2, l2);
      join
      chk("pair_f_lat", l1, 3);
      chk("pair_d_lat", l2, 6);
    end

    // both held continuously: strict alternation
    tick();
    seq.delete();
    fork
      agent(0, 4, 0);
      agent(1, 4, 0);
    join
    chk("alt_len", seq.size(), 8);
    for (int i = 0; i < seq.size(); i++)
      chk("alt_order", seq[i], i % 2);

    // reset during the access cycle of a write
    tick();
    bus.d_req = 1'b1;
    bus.d_we = 1'b1;
    bus.d_addr = 5'h10;
    bus.d_wdata = 8'h55;
    tick();
    chk("mid_we", ram_WE, 1);
    chk("mid_addr", ram_addr, 5'h10);
    Reset = 1'b1;
    #1;
    chk("mid_rst_we", ram_WE, 0);
    chk("mid_rst_init", ram_Initialize, 1);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_addr", {ram_addr, ram_data_IN}, 0);
    bus.d_req = 1'b0;
    act = 0;
    repeat (3) begin
      tick();
      act |= bus.d_ack | bus.f_ack;
    end
    Reset = 1'b0;
    wait_init(n);
    act |= bus.d_ack | bus.f_ack;
    chk("mid_no_ack", act, 0);
    chk("mid_init_edges", n, 2);
    load_ref();
    xfer(1, 0, 5'h10, 8'h00, r1, l1);
    chk("mid_rd10", r1, 8'h1E);

    // request pending across INIT
    Reset = 1'b1;
    bus.f_req = 1'b1;
    bus.f_addr = 5'd5;
    tick();
    Reset = 1'b0;
    load_ref();
    n = 0;
    act = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (n <= 2)
        act |= bus.f_ack | ram_WE | (ram_addr != 5'd0);
      if (bus.f_ack) break;
    end
    bus.f_req = 1'b0;
    chk("init_quiet", act, 0);
    chk("init_ack_edge", n, 5);
    chk("init_f_rdata", bus.f_rdata, 8'h7F);

    // random mixed traffic
    tick();
    fork
      agent(0, 40, 3);
      agent(1, 40, 3);
    join
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
